// File: rtl/pio_tx_fifo_if.sv
// pio_tx_fifo_if: system/state-machine side signals of the PIO TX FIFO.
// tx_join exists only when PIO_FIFO_JOIN_EN is defined.
interface pio_tx_fifo_if #(
  parameter int WIDTH = 32,
  parameter int LW = 4
);
  logic penable, push, pull, clr_flags;
  logic [WIDTH-1:0] din, dout;
  logic full, empty, tx_over, tx_stall;
  logic [LW-1:0] level;
`ifdef PIO_FIFO_JOIN_EN
  logic tx_join;
  modport master(output penable, push, din, pull, clr_flags, tx_join, input dout, full, empty, level, tx_over, tx_stall);
  modport slave(input penable, push, din, pull, clr_flags, tx_join, output dout, full, empty, level, tx_over, tx_stall);
`else
  modport master(output penable, push, din, pull, clr_flags, input dout, full, empty, level, tx_over, tx_stall);
  modport slave(input penable, push, din, pull, clr_flags, output dout, full, empty, level, tx_over, tx_stall);
`endif
endinterface

// File: rtl/pio_tx_fifo.sv
// pio_tx_fifo: first-word-fall-through TX FIFO feeding the PIO OSR, with sticky stall/overflow flags.
// PIO_FIFO_JOIN_EN adds tx_join, which doubles capacity and flushes the FIFO whenever it changes.
module pio_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LW = $clog2(DEPTH) + 2
) (
  input logic clk,
  input logic reset,
  pio_tx_fifo_if.slave f
);
`ifdef PIO_FIFO_JOIN_EN
  localparam int SD = 2 * DEPTH;
`else
  localparam int SD = DEPTH;
`endif
  localparam int PW = $clog2(SD);
  logic [WIDTH-1:0] mem_q [SD];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d, cap;
  logic tx_over_q, tx_over_d, tx_stall_q, tx_stall_d, join_q, join_d;
  logic flush, qpull, do_push, do_pop, full_w, empty_w;
  always_comb begin
`ifdef PIO_FIFO_JOIN_EN
    cap = f.tx_join ? LW'(2 * DEPTH) : LW'(DEPTH);
    join_d = f.tx_join;
`else
    cap = LW'(DEPTH);
    join_d = 1'b0;
`endif
    flush = join_d != join_q;
    full_w = level_q == cap;
    empty_w = level_q == '0;
    qpull = f.pull & f.penable;
    do_pop = qpull & ~empty_w & ~flush;
    // at full a qualified pull always pops, so the push slot is freed in the same cycle
    do_push = f.push & (~full_w | qpull) & ~flush;
    wptr_d = flush ? '0 : do_push ? ((LW'(wptr_q) == cap - 1'b1) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d = flush ? '0 : do_pop ? ((LW'(rptr_q) == cap - 1'b1) ? '0 : rptr_q + 1'b1) : rptr_q;
    level_d = flush ? '0 : level_q + LW'(do_push) - LW'(do_pop);
    tx_over_d = (f.push & full_w & ~qpull & ~flush) | (tx_over_q & ~f.clr_flags);
    tx_stall_d = (qpull & empty_w & ~flush) | (tx_stall_q & ~f.clr_flags);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      tx_over_q <= 1'b0;
      tx_stall_q <= 1'b0;
      join_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      tx_over_q <= tx_over_d;
      tx_stall_q <= tx_stall_d;
      join_q <= join_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wptr_q] <= f.din;
  assign f.dout = empty_w ? '0 : mem_q[rptr_q];
  assign f.full = full_w;
  assign f.empty = empty_w;
  assign f.level = level_q;
  assign f.tx_over = tx_over_q;
  assign f.tx_stall = tx_stall_q;
endmodule

// File: tb/tb_pio_tx_fifo.sv
// tb_pio_tx_fifo: directed plus random stimulus against a queue-based FIFO model, checked by a scoreboard monitor.
module tb_pio_tx_fifo;
  localparam int WIDTH = 32, DEPTH = 4, LW = $clog2(DEPTH) + 2;
`ifdef PIO_FIFO_JOIN_EN
  localparam bit JOIN = 1'b1;
`else
  localparam bit JOIN = 1'b0;
`endif
  logic clk = 1'b0, reset;
  always #5 clk = ~clk;
  pio_tx_fifo_if #(.WIDTH(WIDTH), .LW(LW)) f();
  pio_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW)) dut(.clk(clk), .reset(reset), .f(f));
  typedef struct {int lvl; int cap; bit over; bit stall; bit pop; bit flush; logic [WIDTH-1:0] dout;} st_t;
  st_t st_q[$];
  logic [WIDTH-1:0] data_q[$], m_q[$];
  bit m_over, m_stall, m_join;
  int checks = 0, failures = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask
  task automatic drive(input bit p, input logic [WIDTH-1:0] d, input bit pl, input bit pe, input bit c, input bit j);
    f.push = p; f.din = d; f.pull = pl; f.penable = pe; f.clr_flags = c;
`ifdef PIO_FIFO_JOIN_EN
    f.tx_join = j;
`endif
  endtask
  task automatic rst();
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, '0, 0, 0, 0, 0);
    m_q.delete(); m_over = 0; m_stall = 0; m_join = 0;
    st_q.push_back('{0, DEPTH, 0, 0, 0, 0, '0});
  endtask
  task automatic cyc(input bit p, input logic [WIDTH-1:0] d, input bit pl, input bit pe, input bit c, input bit j);
    int cap, n;
    bit fl, qp, popped;
    @(posedge clk); #1;
    reset = 1'b1;
    drive(p, d, pl, pe, c, j);
    cap = (JOIN && j) ? 2 * DEPTH : DEPTH;
    n = m_q.size();
    fl = JOIN && (j != m_join);
    qp = pl && pe;
    popped = !fl && qp && n > 0;
    st_q.push_back('{n, cap, m_over, m_stall, popped, fl, (n > 0) ? m_q[0] : '0});
    m_over = (!fl && p && n == cap && !qp) || (m_over && !c);
    m_stall = (!fl && qp && n == 0) || (m_stall && !c);
    m_join = j;
    if (fl) m_q.delete();
    else begin
      if (popped) begin
        data_q.push_back(m_q[0]);
        void'(m_q.pop_front());
      end
      if (p && (n < cap || popped)) m_q.push_back(d);
    end
  endtask
  always @(negedge clk) begin
    st_t e;
    bit pres;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      chk("level", f.level, e.lvl);
      chk("empty", f.empty, e.lvl == 0);
      chk("full", f.full, e.lvl == e.cap);
      chk("tx_over", f.tx_over, e.over);
      chk("tx_stall", f.tx_stall, e.stall);
      chk("dout", f.dout, e.dout);
      pres = reset && f.pull && f.penable && !f.empty && !e.flush;
      chk("pop_presented", pres, e.pop);
      if (pres) begin
        if (data_q.size() == 0) chk("pop_unexpected", 1, 0);
        else chk("pop_data", f.dout, data_q.pop_front());
      end
    end
  end
  initial begin
    bit cj;
    reset = 1'b0;
    drive(0, '0, 0, 0, 0, 0);
    rst(); rst();
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 32'hA000_0000 + i, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 32'hB000_0000 + i, 0, 1, 0, 0);
    cyc(1, 32'hDEAD_BEEF, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 32'hC000_0000 + i, 0, 1, 0, 0);
    cyc(1, 32'h55, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 32'h11, 0, 0, 0, 0);
    cyc(1, 32'h22, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    if (JOIN) begin
      cyc(0, 0, 0, 1, 0, 1);
      for (int i = 1; i <= 9; i++) cyc(1, 32'hD000_0000 + i, 0, 1, 0, 1);
      cyc(0, 0, 0, 1, 0, 1);
      cyc(1, 32'hE000_0001, 1, 1, 0, 0);
      cyc(0, 0, 0, 1, 1, 0);
    end
    cyc(1, 32'h77, 0, 1, 0, 0);
    rst();
    cyc(1, 32'h88, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cj = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) rst();
      if (JOIN && $urandom_range(0, 39) == 0) cj = ~cj;
      cyc($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, cj);
    end
    @(posedge clk); #1;
    drive(0, '0, 0, 0, 0, cj);
    @(negedge clk); #1;
    chk("scoreboard_drained", data_q.size(), 0);
    chk("status_drained", st_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pio_tx_fifo.md
Name: pio_tx_fifo

Overview:
- TX FIFO of one PIO state machine; sits directly upstream of the OSR shifter.
- The system side pushes 32-bit words. The state-machine side pulls the head word into the OSR (shifter `set`/`din`).
- The head word is presented first-word-fall-through.
- Provides full/empty/level status and sticky stall/overflow flags for the PIO FDEBUG register.

Parameters:
- WIDTH, 32, data word width; must match the shifter din width.
- DEPTH, 4, word entries (power of two, >=2).
- LW, $clog2(DEPTH)+2, width of the level output; sized for the joined depth 2*DEPTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- penable  input  1  PIO clock-divider enable; qualifies pull only.
- push  input  1  system-side write strobe.
- din  input  WIDTH  system-side write data.
- pull  input  1  state-machine pull request (OSR load).
- dout  output  WIDTH  head word; 0 when empty.
- full  output  1  FIFO holds current capacity words.
- empty  output  1  FIFO holds 0 words.
- level  output  LW  number of words held.
- tx_over  output  1  sticky: push attempted while full and not simultaneously popped.
- tx_stall  output  1  sticky: qualified pull attempted while empty.
- clr_flags  input  1  clears tx_over and tx_stall.
- join  input  1  present only with PIO_FIFO_JOIN_EN; capacity becomes 2*DEPTH.

Behaviour:
- Reset (reset==0, async):
  - pointers and level = 0; dout = 0.
  - empty = 1, full = 0, tx_over = 0, tx_stall = 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all words; the first push after release is the first word out.
- Capacity C = DEPTH, or 2*DEPTH when join=1 (macro on).
- Pointers: write and read pointers wrap modulo C. Level counter 0..C; full = (level==C), empty = (level==0).
- Push:
  - push=1 and not full: din is written at wptr and level increments.
  - Push is independent of penable.
- Pull:
  - Qualified pull = pull & penable.
  - Qualified pull and not empty: rptr advances and level decrements.
  - dout shows the head word combinationally from storage (no extra latency). A word pushed at edge N is visible on dout after edge N.
- Simultaneous push + qualified pull:
  - 0<level<C: both happen, level unchanged.
  - level==C: pop and push both accepted; level stays C, no overflow.
  - level==0: push accepted, pull is a stall (no bypass); level becomes 1 and tx_stall sets.
- Overflow: push while full without a simultaneous qualified pull drops din, leaves storage unchanged, and sets tx_over.
- Stall: qualified pull while empty leaves the FIFO unchanged, sets tx_stall, and dout stays 0.
- Sticky flags: clr_flags=1 clears both flags. A set event in the same cycle as clr_flags wins (flag ends at 1).
- Unqualified pull (penable=0) has no effect and never sets tx_stall.

Optional Feature:
- Macro: PIO_FIFO_JOIN_EN.
- With the macro:
  - join port exists and storage is 2*DEPTH words; C follows join.
  - Any change of join (sampled each clock) flushes the FIFO in that cycle: level = 0, pointers = 0, flags unchanged.
  - A push or pull in the flush cycle is ignored.
- Without the macro:
  - No join port; storage is DEPTH words and C = DEPTH.
  - level still uses LW bits, with the MSB always 0 when DEPTH is a power of two.

Test Plan:
- Reset/empty read: reset low then high, hold penable=1, pull=1 for 1 cycle -> empty=1, level=0, dout=0, tx_stall=1; clr_flags pulse -> tx_stall=0.
- Ordering: push 0xA0000001..0xA0000004 (DEPTH=4) -> full=1, level=4; four qualified pulls -> dout sequence 0xA0000001..0xA0000004, then empty=1.
- Overflow: fill with 4 words, push 0xDEADBEEF -> tx_over=1, level=4; drain -> 0xDEADBEEF never appears.
- Simultaneous at full: 4 words held, push 0x55 + qualified pull same cycle -> level=4, no tx_over; drain order ends with 0x55.
- penable gating: 2 words held, pull=1 with penable=0 for 5 cycles -> level=2, tx_stall=0; one cycle with penable=1 -> level=1.
- Join (macro on): join=1, push 8 words -> full only after 8th, level=8; toggle join to 0 -> level=0, empty=1 next cycle.
